// File: rtl/data_mem_mmio.sv
// Data-memory responder for the single-cycle MIPS core. It combines the
// word-addressed data RAM with a small peripheral page: a free-running cycle
// counter, a GPIO output register, and a TX FIFO that an external
// valid/ready consumer drains.
`timescale 1ns/1ps

module data_mem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int GPIO_W     = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic [GPIO_W-1:0] GPIOOut,
    output logic              TxValid,
    output logic [31:0]       TxData,
    input  logic              TxReady
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    // Word addresses (byte address >> 2) of the peripheral registers
    localparam logic [29:0] W_CYCLE  = 30'h3FFF_C000;
    localparam logic [29:0] W_GPIO   = 30'h3FFF_C001;
    localparam logic [29:0] W_TXDATA = 30'h3FFF_C002;
    localparam logic [29:0] W_STATUS = 30'h3FFF_C003;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [31:0]        ram [RAM_WORDS];
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [31:0]        cycle_cnt;
    logic [GPIO_W-1:0]  gpio_q;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    logic [29:0]        word_addr;
    logic [RAM_AW-1:0]  ram_idx;
    logic               in_ram;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               push_ok;
    logic               ovf_clear;
    logic [31:0]        status_word;
    logic               unused_addr_lsb;

    assign word_addr       = ALUResult[31:2];
    assign ram_idx         = ALUResult[RAM_AW+1:2];
    // No aliasing: every address bit above the RAM index must be zero
    assign in_ram          = (ALUResult[31:RAM_AW+2] == '0);
    assign unused_addr_lsb = ^ALUResult[1:0];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign push       = MemWrite && (word_addr == W_TXDATA);
    assign pop        = TxValid && TxReady;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push_ok    = push && (!fifo_full || pop);
    assign ovf_clear  = MemWrite && (word_addr == W_STATUS) && WriteData[8];

    assign TxValid = !fifo_empty;
    assign TxData  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
    assign GPIOOut = gpio_q;

    assign status_word = {8'h00, 8'(count), 7'h00, overflow, 6'h00, fifo_full, fifo_empty};

    // Combinational load path; old RAM contents are visible during a store
    always_comb begin
        ReadData = 32'h0;
        if (in_ram) begin
            ReadData = ram[ram_idx];
        end else begin
            case (word_addr)
                W_CYCLE:  ReadData = cycle_cnt;
                W_GPIO:   ReadData = 32'(gpio_q);
                W_STATUS: ReadData = status_word;
                default:  ReadData = 32'h0;
            endcase
        end
    end

    // Data RAM store port; contents survive reset
    always_ff @(posedge CLK) begin
        if (MemWrite && in_ram) begin
            ram[ram_idx] <= WriteData;
        end
    end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'h1;
        end
    end

    // GPIO output register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            gpio_q <= '0;
        end else if (MemWrite && (word_addr == W_GPIO)) begin
            gpio_q <= WriteData[GPIO_W-1:0];
        end
    end

    // FIFO storage; stale entries are masked by the empty check on TxData
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a new overflow beats a clear)
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed vector table, hand-written
// FIFO / cycle / async-reset sequences, and randomized bus traffic checked
// against a queue-based reference model of the memory map.
`timescale 1ns/1ps

module tb_data_mem_mmio;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_GPIO   = 32'hFFFF_0004;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        TxReady = 1'b0;
    logic [31:0] ReadData;
    logic [7:0]  GPIOOut;
    logic        TxValid;
    logic [31:0] TxData;

    data_mem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4), .GPIO_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .GPIOOut(GPIOOut),
        .TxValid(TxValid), .TxData(TxData), .TxReady(TxReady)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ram_m [64];
    bit          ram_k [64];
    logic [31:0] q_m [$];
    logic [7:0]  gpio_m;
    bit          ovf_m;
    logic [31:0] cyc_m;

    typedef struct {
        bit          mw;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          rdy;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_valid;
        logic [31:0] exp_txd;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input bit mw, input logic [31:0] addr, input logic [31:0] wd,
                                input bit rdy, input bit chk_rd, input logic [31:0] exp_rd,
                                input bit exp_valid, input logic [31:0] exp_txd,
                                input logic [7:0] exp_gpio);
        vec_t v;
        v.mw = mw; v.addr = addr; v.wd = wd; v.rdy = rdy; v.chk_rd = chk_rd;
        v.exp_rd = exp_rd; v.exp_valid = exp_valid; v.exp_txd = exp_txd; v.exp_gpio = exp_gpio;
        vecs.push_back(v);
    endfunction

    function automatic void model_reset();
        q_m.delete();
        gpio_m = 8'h0;
        ovf_m  = 1'b0;
        cyc_m  = 32'h0;
    endfunction

    function automatic logic [31:0] status_m();
        return {8'h00, 8'(q_m.size()), 7'h00, ovf_m, 6'h00, q_m.size() == 4, q_m.size() == 0};
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] exp;
        bit known;
        known = 1'b1;
        exp = 32'h0;
        if (ALUResult < 32'h100) begin
            known = ram_k[ALUResult[7:2]];
            exp = ram_m[ALUResult[7:2]];
        end else begin
            case ({ALUResult[31:2], 2'b00})
                A_CYCLE:  exp = cyc_m;
                A_GPIO:   exp = {24'h0, gpio_m};
                A_STATUS: exp = status_m();
                default:  exp = 32'h0;
            endcase
        end
        if (known) chk({tag, ".rd"}, ReadData, exp);
        chk({tag, ".valid"}, TxValid, q_m.size() != 0);
        chk({tag, ".txdata"}, TxData, (q_m.size() != 0) ? q_m[0] : 32'h0);
        chk({tag, ".gpio"}, GPIOOut, gpio_m);
    endtask

    task automatic drive(input bit mw, input logic [31:0] addr, input logic [31:0] wd,
                         input bit rdy, input string tag);
        @(negedge CLK);
        MemWrite = mw; ALUResult = addr; WriteData = wd; TxReady = rdy;
        #1;
        check_model(tag);
    endtask

    // Advance one rising edge and apply the same bus cycle to the model
    task automatic commit();
        bit pop, push, drop;
        @(posedge CLK);
        pop  = (q_m.size() != 0) && TxReady;
        push = MemWrite && ({ALUResult[31:2], 2'b00} == A_TXDATA);
        drop = push && (q_m.size() == 4) && !pop;
        if (pop) void'(q_m.pop_front());
        if (push && !drop) q_m.push_back(WriteData);
        if (MemWrite && ({ALUResult[31:2], 2'b00} == A_STATUS) && WriteData[8]) ovf_m = 1'b0;
        if (drop) ovf_m = 1'b1;
        if (MemWrite && ALUResult < 32'h100) begin
            ram_m[ALUResult[7:2]] = WriteData;
            ram_k[ALUResult[7:2]] = 1'b1;
        end
        if (MemWrite && ({ALUResult[31:2], 2'b00} == A_GPIO)) gpio_m = WriteData[7:0];
        cyc_m = cyc_m + 32'h1;
    endtask

    task automatic step(input bit mw, input logic [31:0] addr, input logic [31:0] wd,
                        input bit rdy, input string tag);
        drive(mw, addr, wd, rdy, tag);
        commit();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] va, vb;
        logic [31:0] drain [4];
        for (int i = 0; i < 64; i++) ram_k[i] = 1'b0;
        model_reset();

        // Reset state, observed while reset is held
        ALUResult = A_CYCLE;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst.cycle", ReadData, 32'h0);
        chk("rst.gpio", GPIOOut, 8'h0);
        chk("rst.valid", TxValid, 1'b0);
        chk("rst.txdata", TxData, 32'h0);
        ALUResult = A_STATUS;
        #1;
        chk("rst.status", ReadData, 32'h0000_0001);
        @(posedge CLK);
        #2 Reset = 1'b1;

        // Directed table, starting at cycle 0 after reset release
        add(1, 32'h0000_0000, 32'h1111_1111, 0, 0, 32'h0,          0, 32'h0,  8'h00);
        add(1, 32'h0000_0100, 32'hCAFE_F00D, 0, 1, 32'h0,          0, 32'h0,  8'h00);
        add(0, 32'h0000_0000, 32'h0,         0, 1, 32'h1111_1111,  0, 32'h0,  8'h00);
        add(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0,          0, 32'h0,  8'h00);
        add(0, 32'h0000_0010, 32'h0,         0, 1, 32'hDEAD_BEEF,  0, 32'h0,  8'h00);
        add(1, 32'h0000_00FC, 32'h1234_5678, 0, 0, 32'h0,          0, 32'h0,  8'h00);
        add(0, 32'h0000_00FF, 32'h0,         0, 1, 32'h1234_5678,  0, 32'h0,  8'h00);
        add(1, A_GPIO,        32'h0000_01A5, 0, 1, 32'h0,          0, 32'h0,  8'h00);
        add(0, A_GPIO,        32'h0,         0, 1, 32'h0000_00A5,  0, 32'h0,  8'hA5);
        add(1, A_CYCLE,       32'hFFFF_FFFF, 0, 1, 32'd9,          0, 32'h0,  8'hA5);
        add(0, A_CYCLE,       32'h0,         0, 1, 32'd10,         0, 32'h0,  8'hA5);
        add(1, A_TXDATA,      32'h0000_0055, 0, 1, 32'h0,          0, 32'h0,  8'hA5);
        add(0, A_TXDATA,      32'h0,         0, 1, 32'h0,          1, 32'h55, 8'hA5);
        add(0, A_STATUS,      32'h0,         1, 1, 32'h0001_0000,  1, 32'h55, 8'hA5);
        add(0, A_STATUS,      32'h0,         0, 1, 32'h0000_0001,  0, 32'h0,  8'hA5);
        foreach (vecs[i]) begin
            drive(vecs[i].mw, vecs[i].addr, vecs[i].wd, vecs[i].rdy, $sformatf("vec%0d", i));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d.rd_const", i), ReadData, vecs[i].exp_rd);
            chk($sformatf("vec%0d.valid_const", i), TxValid, vecs[i].exp_valid);
            chk($sformatf("vec%0d.txd_const", i), TxData, vecs[i].exp_txd);
            chk($sformatf("vec%0d.gpio_const", i), GPIOOut, vecs[i].exp_gpio);
            commit();
        end

        // Cycle counter advances by exactly 5 over 5 edges
        drive(0, A_CYCLE, 0, 0, "cyc.a");
        va = ReadData;
        commit();
        repeat (4) step(0, 32'h0000_0200, 0, 0, "cyc.idle");
        drive(0, A_CYCLE, 0, 0, "cyc.b");
        vb = ReadData;
        commit();
        chk("cycle.diff", vb - va, 32'd5);

        // FIFO fill, overflow, push+pop at full, overflow clear, drain
        for (int i = 1; i <= 4; i++) step(1, A_TXDATA, i, 0, "fill");
        drive(0, A_STATUS, 0, 0, "full.status");
        chk("full.status_const", ReadData, 32'h0004_0002);
        chk("full.head_const", TxData, 32'h1);
        commit();
        step(1, A_TXDATA, 32'h5, 0, "ovf.push");
        drive(0, A_STATUS, 0, 0, "ovf.status");
        chk("ovf.status_const", ReadData, 32'h0004_0102);
        commit();
        drive(1, A_TXDATA, 32'h9, 1, "pushpop");
        chk("pushpop.head_const", TxData, 32'h1);
        commit();
        drive(0, A_STATUS, 0, 0, "pushpop.status");
        chk("pushpop.status_const", ReadData, 32'h0004_0102);
        chk("pushpop.head2_const", TxData, 32'h2);
        commit();
        step(1, A_STATUS, 32'h0000_0100, 0, "ovf.clear");
        drive(0, A_STATUS, 0, 0, "clr.status");
        chk("clr.status_const", ReadData, 32'h0004_0002);
        commit();
        drain[0] = 32'h2; drain[1] = 32'h3; drain[2] = 32'h4; drain[3] = 32'h9;
        for (int i = 0; i < 4; i++) begin
            drive(0, A_GPIO, 0, 1, "drain");
            chk($sformatf("drain%0d.txd_const", i), TxData, drain[i]);
            commit();
        end
        drive(0, A_STATUS, 0, 1, "drained");
        chk("drained.valid_const", TxValid, 1'b0);
        commit();

        // Asynchronous reset in the middle of a cycle
        step(1, A_GPIO, 32'h3C, 0, "ar.gpio");
        step(1, A_TXDATA, 32'h77, 0, "ar.push");
        step(0, A_CYCLE, 0, 0, "ar.idle");
        MemWrite = 1'b0;
        #2 Reset = 1'b0;
        #1;
        chk("async.gpio", GPIOOut, 8'h0);
        chk("async.valid", TxValid, 1'b0);
        chk("async.cycle", ReadData, 32'h0);
        model_reset();
        repeat (2) @(posedge CLK);
        #2 Reset = 1'b1;
        step(0, A_STATUS, 0, 0, "ar.status");

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r, addr, wd;
            bit mw, rdy;
            r = $urandom;
            wd = $urandom;
            case ($urandom_range(0, 5))
                0: addr = {24'h0, r[7:0]};
                1: addr = A_CYCLE  | {30'h0, r[1:0]};
                2: addr = A_GPIO   | {30'h0, r[1:0]};
                3: addr = A_TXDATA | {30'h0, r[1:0]};
                4: addr = A_STATUS | {30'h0, r[1:0]};
                default: addr = 32'h100 + (r % 32'hFFFE_0000);
            endcase
            mw  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            step(mw, addr, wd, rdy, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
